// File: rtl/instr_mem_resp_if.sv
// Instruction fetch bus: the initiator drives request/address, the memory
// answers with a combinational grant and a fixed-latency, in-order response.
interface instr_mem_resp_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );
endinterface

// File: rtl/instr_mem_resp.sv
// Instruction memory responder: word-addressed backing store with a loader
// write port, bounded outstanding requests and a fixed-latency response pipe.
module instr_mem_resp #(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  instr_mem_resp_if.slave        bus,
  input  logic                   gnt_block_i,
  input  logic                   load_we_i,
  input  logic [31:0]            load_addr_i,
  input  logic [31:0]            load_wdata_i,
  output logic [2:0]             outstanding_o
);

  localparam int          IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) * 33'd4);

  // BASE_ADDR and END_ADDR are word aligned, so the two low address bits never change the outcome.
  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  logic [31:0]              mem_q [MEM_WORDS];
  logic [2:0]               count_q, count_d;
  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0]       err_q, err_d;
  logic [LATENCY-1:0][31:0] data_q, data_d;
  logic                     gnt_s;
  logic                     hit_s;
  logic [31:0]              rd_s;

  // Grant, grant-cycle read and response pipe advance; count excludes the entry entering the output stage.
  always_comb begin
    gnt_s = rstn & bus.instr_req_i & ~gnt_block_i & (count_q < 3'(MAX_OUTSTANDING));
    hit_s = in_range(bus.instr_addr_i);
    if (gnt_s && hit_s) begin
      rd_s = mem_q[word_idx(bus.instr_addr_i)];
    end else begin
      rd_s = 32'h0000_0000;
    end
    vld_d     = {LATENCY{1'b0}};
    err_d     = {LATENCY{1'b0}};
    data_d    = {LATENCY{32'h0000_0000}};
    vld_d[0]  = gnt_s;
    err_d[0]  = gnt_s & ~hit_s;
    data_d[0] = rd_s;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
    count_d = count_q + {2'b00, gnt_s} - {2'b00, vld_d[LATENCY-1]};
  end

  // Response pipe and outstanding count; reset discards everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= 3'd0;
      vld_q   <= {LATENCY{1'b0}};
      err_q   <= {LATENCY{1'b0}};
      data_q  <= {LATENCY{32'h0000_0000}};
    end else begin
      count_q <= count_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Backing store has no reset so a loaded program survives rstn; same-edge reads see the old word.
  always_ff @(posedge clk) begin
    if (load_we_i && in_range(load_addr_i)) begin
      mem_q[word_idx(load_addr_i)] <= load_wdata_i;
    end
  end

  assign bus.instr_gnt_o    = gnt_s;
  assign bus.instr_rvalid_o = vld_q[LATENCY-1];
  assign bus.instr_err_o    = err_q[LATENCY-1];
  assign bus.instr_rdata_o  = data_q[LATENCY-1];
  assign outstanding_o      = count_q;

endmodule

// File: tb/tb_instr_mem_resp.sv
// Bench for instr_mem_resp: two instances (LATENCY 1 at base 0, LATENCY 3 at base 0x100)
// checked every cycle against a reference memory, a response scoreboard and a grant model.
module tb_instr_mem_resp;

  localparam int          WORDS  = 1024;
  localparam int          LAT_A  = 1;
  localparam int          MAX_A  = 2;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam int          LAT_B  = 3;
  localparam int          MAX_B  = 2;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  typedef struct {
    int          k;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic        clk = 1'b0;
  logic        rstn;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        blk   [2];
  logic        lwe   [2];
  logic [31:0] laddr [2];
  logic [31:0] lwd   [2];
  logic [2:0]  os_a, os_b;
  logic [31:0] mmem  [2][WORDS];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  instr_mem_resp_if ifa ();
  instr_mem_resp_if ifb ();

  assign ifa.instr_req_i  = req[0];
  assign ifa.instr_addr_i = addr[0];
  assign ifb.instr_req_i  = req[1];
  assign ifb.instr_addr_i = addr[1];

  instr_mem_resp #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE_A), .LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa), .gnt_block_i(blk[0]), .load_we_i(lwe[0]),
    .load_addr_i(laddr[0]), .load_wdata_i(lwd[0]), .outstanding_o(os_a)
  );

  instr_mem_resp #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE_B), .LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb), .gnt_block_i(blk[1]), .load_we_i(lwe[1]),
    .load_addr_i(laddr[1]), .load_wdata_i(lwd[1]), .outstanding_o(os_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  function automatic string tg(input string s, input int k);
    return $sformatf("%s[%s]", s, (k == 0) ? "a" : "b");
  endfunction

  function automatic logic m_in(input int k, input logic [31:0] a);
    longint unsigned base, la;
    base = (k == 0) ? longint'(BASE_A) : longint'(BASE_B);
    la   = longint'(a);
    return (la >= base) && (la < base + 4 * WORDS);
  endfunction

  function automatic int m_idx(input int k, input logic [31:0] a);
    longint unsigned base;
    base = (k == 0) ? longint'(BASE_A) : longint'(BASE_B);
    return int'((longint'(a) - base) / 4);
  endfunction

  // Per-cycle checking of one instance at the falling edge.
  task automatic mon(input int k, input logic gnt, input logic rv, input logic [31:0] rd,
                     input logic er, input logic [2:0] os);
    int   lat, mx, found, pend;
    logic exp_g;
    exp_t e;
    lat = (k == 0) ? LAT_A : LAT_B;
    mx  = (k == 0) ? MAX_A : MAX_B;
    if (!rstn) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].k == k) sb.delete(i);
      check_val(tg("rst_rvalid", k), 32'(rv), 32'd0);
      check_val(tg("rst_rdata", k), rd, 32'd0);
      check_val(tg("rst_err", k), 32'(er), 32'd0);
      check_val(tg("rst_outstanding", k), 32'(os), 32'd0);
      check_val(tg("rst_gnt", k), 32'(gnt), 32'd0);
    end else begin
      found = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].k == k) begin
          found = i;
          break;
        end
      end
      if (rv) begin
        if (found < 0) begin
          check_val(tg("spurious_rvalid", k), 32'(rv), 32'd0);
        end else begin
          e = sb[found];
          sb.delete(found);
          check_val(tg("resp_cycle", k), 32'(cyc), 32'(e.due));
          check_val(tg("rdata", k), rd, e.data);
          check_val(tg("err", k), 32'(er), 32'(e.err));
        end
      end else begin
        check_val(tg("idle_rdata", k), rd, 32'd0);
        check_val(tg("idle_err", k), 32'(er), 32'd0);
        if (found >= 0 && sb[found].due <= cyc) begin
          check_val(tg("missing_rvalid", k), 32'(rv), 32'd1);
          sb.delete(found);
        end
      end
      pend = 0;
      foreach (sb[i]) if (sb[i].k == k && sb[i].due > cyc) pend++;
      check_val(tg("outstanding", k), 32'(os), 32'(pend));
      exp_g = req[k] && !blk[k] && (pend < mx);
      check_val(tg("gnt", k), 32'(gnt), 32'(exp_g));
      if (req[k] && gnt) begin
        e.k    = k;
        e.err  = !m_in(k, addr[k]);
        e.data = e.err ? 32'd0 : mmem[k][m_idx(k, addr[k])];
        e.due  = cyc + lat;
        sb.push_back(e);
      end
    end
    if (lwe[k] && m_in(k, laddr[k])) mmem[k][m_idx(k, laddr[k])] = lwd[k];
  endtask

  always @(negedge clk) begin
    mon(0, ifa.instr_gnt_o, ifa.instr_rvalid_o, ifa.instr_rdata_o, ifa.instr_err_o, os_a);
    mon(1, ifb.instr_gnt_o, ifb.instr_rvalid_o, ifb.instr_rdata_o, ifb.instr_err_o, os_b);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    lwe[k] = 1'b1; laddr[k] = a; lwd[k] = d;
    tick(1);
    lwe[k] = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] a);
    req[k] = 1'b1; addr[k] = a;
    tick(1);
    req[k] = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = 32'd0; blk[k] = 1'b0;
      lwe[k] = 1'b0; laddr[k] = 32'd0; lwd[k] = 32'd0;
    end
    tick(3);
    rstn = 1'b1;

    // Instance a: back-to-back fetch of two loaded words.
    load(0, 32'h0000_0000, 32'h0000_0013);
    load(0, 32'h0000_0004, 32'h0010_0093);
    load(0, 32'h0000_0008, 32'h0000_0000);
    req[0] = 1'b1; addr[0] = 32'h0000_0000; tick(1);
    addr[0] = 32'h0000_0004; tick(1);
    req[0] = 1'b0; tick(2);

    // Just past the end of the store, then an unaligned in-range address.
    fetch(0, 32'h0000_1000);
    fetch(0, 32'h0000_0006);
    tick(2);

    // Loader write and grant to the same word in one cycle, then refetch.
    req[0] = 1'b1; addr[0] = 32'h0000_0008;
    lwe[0] = 1'b1; laddr[0] = 32'h0000_0008; lwd[0] = 32'hDEAD_BEEF;
    tick(1);
    lwe[0] = 1'b0; tick(1);
    req[0] = 1'b0; tick(2);

    // Backpressure: five blocked cycles, then release with request still high.
    blk[0] = 1'b1; req[0] = 1'b1; addr[0] = 32'h0000_0004; tick(5);
    blk[0] = 1'b0; tick(1);
    req[0] = 1'b0; tick(3);

    // Instance b: random program, request held high against the outstanding limit.
    for (int i = 0; i < 8; i++) load(1, BASE_B + 32'(4 * i), $urandom);
    load(1, 32'h0000_10FC, 32'hCAFE_F00D);
    load(1, 32'h0000_1100, 32'h1234_5678);
    req[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr[1] = BASE_B + 32'(4 * (i % 8));
      tick(1);
    end
    req[1] = 1'b0; tick(4);

    // Range edges around base 0x100.
    fetch(1, 32'hFFFF_FFFC);
    fetch(1, 32'h0000_00FC);
    fetch(1, 32'h0000_10FC);
    fetch(1, 32'h0000_1100);
    tick(4);

    // Reset with two requests in flight; contents must survive.
    req[1] = 1'b1; addr[1] = 32'h0000_0104; tick(2);
    req[1] = 1'b0; rstn = 1'b0; tick(2);
    rstn = 1'b1; req[1] = 1'b1; addr[1] = 32'h0000_0104; tick(1);
    req[1] = 1'b0; tick(6);

    check_val("drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
